// File: rtl/dvp_tx.sv
// dvp_tx: DVP camera-style transmitter.
// Serialises a 16-bit pixel stream into Vsync/Href/Data (8-bit), high byte
// first. Pixels are pulled from upstream with a Pix_Ready/Pix_Valid handshake
// that never stalls line timing; a missing pixel is sent as zero and flagged
// in the sticky Underrun output. Every output is a flop driven from the
// next-state decode, so the value on a pin describes the current DVP cycle.
module dvp_tx #(
  parameter int WIDTH    = 16,
  parameter int HIGHT    = 12,
  parameter int VS_WIDTH = 4,
  parameter int VS_BACK  = 10,
  parameter int H_BLANK  = 10
) (
  input  logic        PCLK,
  input  logic        Rst_n,
  input  logic        Tx_En,
  input  logic [15:0] Pix_Data,
  input  logic        Pix_Valid,
  output logic        Pix_Ready,
  output logic        Vsync,
  output logic        Href,
  output logic [7:0]  Data,
  output logic        Frame_Done,
  output logic        Underrun
);

  localparam int LINE_BYTES = 2 * WIDTH;

  // Phase counter spans the longest of the four timed phases.
  localparam int MAX_A   = (VS_WIDTH > VS_BACK) ? VS_WIDTH : VS_BACK;
  localparam int MAX_B   = (LINE_BYTES > H_BLANK) ? LINE_BYTES : H_BLANK;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int LW      = (HIGHT > 1) ? $clog2(HIGHT) : 1;

  localparam logic [CW-1:0] VS_LAST   = CW'(VS_WIDTH - 1);
  localparam logic [CW-1:0] VB_LAST   = CW'(VS_BACK - 1);
  localparam logic [CW-1:0] LINE_LAST = CW'(LINE_BYTES - 1);
  localparam logic [CW-1:0] HB_LAST   = CW'(H_BLANK - 1);
  localparam logic [LW-1:0] ROW_LAST  = LW'(HIGHT - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBACK  = 3'd2;
  localparam logic [2:0] ST_LINE   = 3'd3;
  localparam logic [2:0] ST_HBLANK = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [LW-1:0] row, row_nxt;
  logic          done_nxt;
  logic          ready_nxt;
  logic [7:0]    data_nxt;
  logic [15:0]   pix_in;
  logic [7:0]    lo_q;

  // Pixel taken on a Pix_Ready cycle; an absent pixel is replaced by zero.
  assign pix_in = Pix_Valid ? Pix_Data : '0;

  // Frame sequencing: phase counter and line counter advance per state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    row_nxt   = row;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Tx_En) begin
          state_nxt = ST_VSYNC;
          cnt_nxt   = '0;
        end
      end
      ST_VSYNC: begin
        if (cnt == VS_LAST) begin
          state_nxt = ST_VBACK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_VBACK: begin
        if (cnt == VB_LAST) begin
          state_nxt = ST_LINE;
          cnt_nxt   = '0;
          row_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_LINE: begin
        if (cnt == LINE_LAST) begin
          state_nxt = ST_HBLANK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_HBLANK: begin
        if (cnt == HB_LAST) begin
          cnt_nxt = '0;
          if (row == ROW_LAST) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_LINE;
            row_nxt   = row + LW'(1);
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        row_nxt   = '0;
      end
    endcase
  end

  // Output decode for the upcoming cycle. Pix_Ready is raised on the cycle
  // that precedes a high byte, so the high byte comes straight from the
  // handshake input while the low byte comes from the held copy.
  always_comb begin
    ready_nxt = 1'b0;
    data_nxt  = 8'h00;
    case (state_nxt)
      ST_VBACK:  ready_nxt = (cnt_nxt == VB_LAST);
      ST_HBLANK: ready_nxt = (cnt_nxt == HB_LAST) && (row_nxt != ROW_LAST);
      ST_LINE: begin
        ready_nxt = cnt_nxt[0] && (cnt_nxt != LINE_LAST);
        data_nxt  = cnt_nxt[0] ? lo_q : pix_in[15:8];
      end
      default: ready_nxt = 1'b0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      row        <= '0;
      Vsync      <= 1'b0;
      Href       <= 1'b0;
      Data       <= 8'h00;
      Pix_Ready  <= 1'b0;
      Frame_Done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      row        <= row_nxt;
      Vsync      <= (state_nxt == ST_VSYNC);
      Href       <= (state_nxt == ST_LINE);
      Data       <= data_nxt;
      Pix_Ready  <= ready_nxt;
      Frame_Done <= done_nxt;
    end
  end

  // Low byte of the accepted pixel, held for the following low-byte cycle.
  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      lo_q <= '0;
    end else if (Pix_Ready) begin
      lo_q <= pix_in[7:0];
    end
  end

  // Sticky underrun: cleared when a new frame starts, set by any empty slot.
  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      Underrun <= 1'b0;
    end else if ((state == ST_IDLE) && Tx_En) begin
      Underrun <= 1'b0;
    end else if (Pix_Ready && !Pix_Valid) begin
      Underrun <= 1'b1;
    end
  end

endmodule

// File: doc/dvp_tx.md
Name: dvp_tx

Overview:
- DVP (camera-style) transmitter: serialises a 16-bit pixel stream into Vsync/Href/8-bit Data, high byte first, two bytes per pixel.
- Drives the same waveform the DVP capture block consumes. Used as a loopback/self-test source on the camera path and as a synthesisable pattern/stream emitter.
- Pixels are pulled from an upstream source (FIFO or pattern generator) via a ready/valid handshake.

Parameters:
- WIDTH, 16, active pixels per line (line carries 2*WIDTH bytes).
- HIGHT, 12, active lines per frame.
- VS_WIDTH, 4, Vsync high time in PCLK cycles (>=1).
- VS_BACK, 10, cycles from Vsync fall to first Href rise (>=2).
- H_BLANK, 10, Href-low cycles between lines and after the last line (>=2).

Ports:
- PCLK  input  1  pixel clock; all logic on rising edge.
- Rst_n  input  1  reset.
- Tx_En  input  1  frame enable, sampled in IDLE only.
- Pix_Data  input  16  pixel from upstream.
- Pix_Valid  input  1  Pix_Data valid.
- Pix_Ready  output  1  block accepts Pix_Data this cycle.
- Vsync  output  1  frame sync, active high.
- Href  output  1  line valid, active high.
- Data  output  8  DVP byte.
- Frame_Done  output  1  one-cycle pulse after the last line's blanking.
- Underrun  output  1  sticky: a pixel slot found Pix_Valid low.

Behaviour:
- Clocking and reset: one clock, PCLK. Reset Rst_n is asynchronous, active-low. Rst_n=0 forces immediately: state IDLE, all counters 0, and Vsync, Href, Pix_Ready, Frame_Done and Underrun all 0, Data=8'h00. Reset mid-frame truncates the frame with no Frame_Done.
- Output timing: all outputs are registered and have no combinational path from inputs.
- States: IDLE -> VSYNC -> VBACK -> LINE <-> HBLANK -> IDLE.
- IDLE:
  - All outputs low.
  - If Tx_En=1, go to VSYNC; Vsync is 1 on the next cycle.
  - Clear Underrun on the IDLE->VSYNC transition.
- VSYNC: Vsync=1 for exactly VS_WIDTH cycles, then VBACK.
- VBACK: VS_BACK cycles with Vsync=0 and Href=0, then LINE, line counter=0.
- LINE:
  - Href=1 for exactly 2*WIDTH cycles. The byte phase alternates, starting with the high byte.
  - On a high-byte cycle, Data = the latched pixel's [15:8]; on the low-byte cycle, Data = its [7:0].
  - Then HBLANK.
- HBLANK:
  - H_BLANK cycles with Href=0 and Data=8'h00.
  - At the end, if the line counter is less than HIGHT-1: increment it and go to LINE.
  - Otherwise go to IDLE, with Frame_Done=1 for that first IDLE cycle.
- Pix_Ready (pixel handshake):
  - High exactly one cycle before each high-byte cycle. That is the last cycle of VBACK or HBLANK for pixel 0, and each low-byte cycle for pixels 1..WIDTH-1.
  - It is never high otherwise, so WIDTH pulses per line and WIDTH*HIGHT per frame.
  - On a Pix_Ready cycle: if Pix_Valid=1, latch Pix_Data. If not, latch 16'h0000 and set Underrun. No stalling; line timing is never stretched.
  - Pix_Valid outside Pix_Ready cycles is ignored.
- Tx_En deasserted mid-frame: the current frame completes normally, then the block stays in IDLE.
- Back-to-back frames with Tx_En held 1:
  - The Vsync rising period is VS_WIDTH + VS_BACK + HIGHT*(2*WIDTH + H_BLANK) + 1 cycles.
  - With the defaults this is 519.
- Counters are sized from the parameters (clog2), and they must not wrap within a frame.

Test Plan:
- Reset/idle: Rst_n=0 then 1, Tx_En=0 for 100 cycles -> all outputs 0, Pix_Ready never asserted.
- Single frame, defaults, Tx_En=1 one cycle, upstream always valid with an incrementing 16'h0000..16'h00BF -> expected waveform:
  - Vsync high 4 cycles, first Href rise 10 cycles after the Vsync fall.
  - 12 Href pulses of 32 cycles with 10-cycle gaps.
  - Byte sequence 00,00,00,01,...,00,BF.
  - Frame_Done pulses once, 10 cycles after the last Href fall. Underrun=0.
- Handshake underflow: drop Pix_Valid for pixel 5 of line 2 -> bytes 00,00 in that slot, the next pixels unchanged, Underrun=1 until the next frame start, line timing unchanged.
- Continuous with Tx_En held 1 for 3 frames -> Vsync rises exactly 519 cycles apart, and each frame has 192 Pix_Ready pulses.
- Reset mid-line: Rst_n low during line 6 -> Href/Vsync/Data/Pix_Ready go 0 asynchronously with no Frame_Done. After release with Tx_En=1, a fresh full frame is sent.
- Loopback: feed Vsync/Href/Data into the DVP capture block with the same WIDTH/HIGHT -> captured DataPixel stream equals the transmitted pixels.
